// File: rtl/vga_fb_fill_ctrl_if.sv
// Bundle of MCU, fill-command and framebuffer write-port signals for vga_fb_fill_ctrl.
// The slave modport is the controller's view; master is the surrounding system's view.
interface vga_fb_fill_ctrl_if;
    logic [10:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        CPU_WE;
    logic [7:0]  CPU_RD;
    logic [5:0]  CMD_X0;
    logic [4:0]  CMD_Y0;
    logic [5:0]  CMD_W;
    logic [4:0]  CMD_H;
    logic [7:0]  CMD_COLOR;
    logic        CMD_START;
    logic        BUSY;
    logic        DONE;
    logic        CMD_ERR;
    logic [10:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        FB_WE;
    logic [7:0]  FB_RD;

    modport slave (
        input  CPU_WA, CPU_WD, CPU_WE,
        input  CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR, CMD_START,
        input  FB_RD,
        output CPU_RD, BUSY, DONE, CMD_ERR,
        output FB_WA, FB_WD, FB_WE
    );

    modport master (
        output CPU_WA, CPU_WD, CPU_WE,
        output CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR, CMD_START,
        output FB_RD,
        input  CPU_RD, BUSY, DONE, CMD_ERR,
        input  FB_WA, FB_WD, FB_WE
    );
endinterface

// File: rtl/vga_fb_fill_ctrl.sv
// Framebuffer write-port owner: arbitrates MCU writes (always first) against a
// rectangle-fill engine that paints a screen-clipped rectangle row-major.
module vga_fb_fill_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic              CLK,
    input  logic              RST,
    vga_fb_fill_ctrl_if.slave bus
);
    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t      r_state;
    logic [5:0]  r_x;
    logic [5:0]  r_x0;
    logic [4:0]  r_y;
    logic [6:0]  r_x_end;
    logic [5:0]  r_y_end;
    logic [7:0]  r_color;
    logic [10:0] r_fb_wa;
    logic [7:0]  r_fb_wd;
    logic        r_fb_we;
    logic        r_done;
    logic        r_err;

    logic [6:0]  w_x_sum;
    logic [5:0]  w_y_sum;
    logic [6:0]  w_x_end;
    logic [5:0]  w_y_end;
    logic        w_cmd_valid;
    logic        w_col_last;
    logic        w_row_last;

    // End bounds are exclusive and one bit wider than the coordinate so the sum cannot wrap.
    assign w_x_sum     = {1'b0, bus.CMD_X0} + {1'b0, bus.CMD_W};
    assign w_y_sum     = {1'b0, bus.CMD_Y0} + {1'b0, bus.CMD_H};
    assign w_x_end     = (w_x_sum > 7'(COLS)) ? 7'(COLS) : w_x_sum;
    assign w_y_end     = (w_y_sum > 6'(ROWS)) ? 6'(ROWS) : w_y_sum;
    assign w_cmd_valid = ({1'b0, bus.CMD_X0} < 7'(COLS)) && ({1'b0, bus.CMD_Y0} < 6'(ROWS))
                         && (bus.CMD_W != 6'd0) && (bus.CMD_H != 5'd0);
    assign w_col_last  = (({1'b0, r_x} + 7'd1) == r_x_end);
    assign w_row_last  = (({1'b0, r_y} + 6'd1) == r_y_end);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_x0    <= '0;
            r_y     <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
            r_color <= '0;
            r_fb_wa <= '0;
            r_fb_wd <= '0;
            r_fb_we <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (bus.CPU_WE) begin
                r_fb_wa <= bus.CPU_WA;
                r_fb_wd <= bus.CPU_WD;
                r_fb_we <= 1'b1;
            end else if (r_state == S_FILL) begin
                r_fb_wa <= {r_y, r_x};
                r_fb_wd <= r_color;
                r_fb_we <= 1'b1;
            end else begin
                // Idle: park the address on the MCU's so FB_RD serves its reads.
                r_fb_wa <= bus.CPU_WA;
                r_fb_we <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.CMD_START) begin
                        if (w_cmd_valid) begin
                            r_x0    <= bus.CMD_X0;
                            r_x     <= bus.CMD_X0;
                            r_y     <= bus.CMD_Y0;
                            r_x_end <= w_x_end;
                            r_y_end <= w_y_end;
                            r_color <= bus.CMD_COLOR;
                            r_state <= S_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // A cycle taken by the MCU leaves the fill position untouched.
                    if (!bus.CPU_WE) begin
                        if (w_col_last) begin
                            r_x <= r_x0;
                            r_y <= r_y + 5'd1;
                            if (w_row_last) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 6'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.FB_WA   = r_fb_wa;
    assign bus.FB_WD   = r_fb_wd;
    assign bus.FB_WE   = r_fb_we;
    assign bus.DONE    = r_done;
    assign bus.CMD_ERR = r_err;
    assign bus.BUSY    = (r_state == S_FILL);
    assign bus.CPU_RD  = bus.FB_RD;
endmodule

// File: tb/tb_vga_fb_fill_ctrl.sv
// Directed and randomized bench for vga_fb_fill_ctrl against a cell-list reference model
// and a shadow framebuffer image.
module tb_vga_fb_fill_ctrl;
    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    vga_fb_fill_ctrl_if bus ();

    vga_fb_fill_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #10 CLK = ~CLK;

    // Framebuffer stand-in: registered write, combinational read at FB_WA.
    logic [7:0] fb_mem [2048] = '{default: 8'h00};
    always @(posedge CLK) if (bus.FB_WE) fb_mem[bus.FB_WA] <= bus.FB_WD;
    assign bus.FB_RD = fb_mem[bus.FB_WA];

    logic [7:0]  ref_mem [2048];
    int          checks = 0;
    int          errors = 0;

    logic [10:0] fill_wa_q[$];
    logic [7:0]  fill_wd_q[$];
    logic [10:0] cpu_wa_q[$];
    logic [7:0]  cpu_wd_q[$];
    logic [10:0] exp_wa[$];
    logic [7:0]  exp_wd[$];
    logic [10:0] cpu_exp_wa[$];
    logic [7:0]  cpu_exp_wd[$];
    int          done_cnt, err_cnt, busy_cnt;
    logic [10:0] done_wa;
    logic        done_we;
    bit          model_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        fill_wa_q.delete(); fill_wd_q.delete();
        cpu_wa_q.delete();  cpu_wd_q.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        done_wa = '0; done_we = 1'b0;
    endtask

    // Advance one clock and log what the DUT presents after that edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.FB_WE) begin
            if (bus.FB_WA >= 11'd1920) begin
                cpu_wa_q.push_back(bus.FB_WA); cpu_wd_q.push_back(bus.FB_WD);
            end else begin
                fill_wa_q.push_back(bus.FB_WA); fill_wd_q.push_back(bus.FB_WD);
            end
        end
        if (bus.DONE) begin
            done_cnt++; done_wa = bus.FB_WA; done_we = bus.FB_WE;
        end
        if (bus.CMD_ERR) err_cnt++;
        if (bus.BUSY) busy_cnt++;
    endtask

    task automatic idle_inputs();
        bus.CPU_WE = 1'b0;
        bus.CMD_START = 1'b0;
    endtask

    // MCU write into rows 30-31, a region no fill can reach.
    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
        bus.CPU_WA = a; bus.CPU_WD = d; bus.CPU_WE = 1'b1;
        cpu_exp_wa.push_back(a); cpu_exp_wd.push_back(d);
    endtask

    // Reference: list of cells the rectangle covers after clipping, row-major.
    task automatic model_fill(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
        int xe, ye;
        exp_wa.delete(); exp_wd.delete();
        model_ok = (x0 < COLS) && (y0 < ROWS) && (w > 0) && (h > 0);
        if (model_ok) begin
            xe = (x0 + w < COLS) ? x0 + w : COLS;
            ye = (y0 + h < ROWS) ? y0 + h : ROWS;
            for (int y = y0; y < ye; y++)
                for (int x = x0; x < xe; x++) begin
                    exp_wa.push_back(11'(y * 64 + x));
                    exp_wd.push_back(c);
                end
        end
    endtask

    task automatic do_cmd(input string tag, input int x0, input int y0, input int w, input int h,
                          input logic [7:0] c, input int burst_at, input int burst_len,
                          input int pct, input int mid_at, input bit cpu_at_start);
        int iter, stalls, n, m, exp_busy;
        bit stall;
        clear_log();
        model_fill(x0, y0, w, h, c);
        cpu_exp_wa.delete(); cpu_exp_wd.delete();
        bus.CMD_X0 = 6'(x0); bus.CMD_Y0 = 5'(y0); bus.CMD_W = 6'(w); bus.CMD_H = 5'(h);
        bus.CMD_COLOR = c; bus.CMD_START = 1'b1;
        if (cpu_at_start) cpu_write(11'(1920 + $urandom_range(127)), 8'($urandom));
        tick();
        idle_inputs();
        iter = 0; stalls = 0;
        while (bus.BUSY && iter < 3000) begin
            stall = 1'b0;
            if (iter >= burst_at && iter < burst_at + burst_len) begin
                cpu_write(11'h7FF, 8'h55); stall = 1'b1;
            end else if (int'($urandom_range(99)) < pct) begin
                cpu_write(11'(1920 + $urandom_range(127)), 8'($urandom)); stall = 1'b1;
            end
            if (stall) stalls++;
            if (iter == mid_at) begin
                bus.CMD_START = 1'b1; bus.CMD_X0 = 6'd0; bus.CMD_Y0 = 5'd0;
                bus.CMD_W = 6'd1; bus.CMD_H = 5'd1; bus.CMD_COLOR = 8'h03;
            end
            tick();
            idle_inputs();
            iter++;
        end
        tick();
        tick();

        n = exp_wa.size();
        m = fill_wa_q.size();
        exp_busy = model_ok ? n + stalls : 0;
        check({tag, "_bounded"}, 32'(iter < 3000), 32'd1);
        check({tag, "_nwrites"}, 32'(m), 32'(n));
        for (int i = 0; i < n && i < m; i++) begin
            check($sformatf("%s_wa%0d", tag, i), 32'(fill_wa_q[i]), 32'(exp_wa[i]));
            check($sformatf("%s_wd%0d", tag, i), 32'(fill_wd_q[i]), 32'(exp_wd[i]));
        end
        check({tag, "_ncpu"}, 32'(cpu_wa_q.size()), 32'(cpu_exp_wa.size()));
        for (int i = 0; i < cpu_exp_wa.size() && i < cpu_wa_q.size(); i++) begin
            check($sformatf("%s_cwa%0d", tag, i), 32'(cpu_wa_q[i]), 32'(cpu_exp_wa[i]));
            check($sformatf("%s_cwd%0d", tag, i), 32'(cpu_wd_q[i]), 32'(cpu_exp_wd[i]));
        end
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done"}, 32'(done_cnt), model_ok ? 32'd1 : 32'd0);
        check({tag, "_err"}, 32'(err_cnt), model_ok ? 32'd0 : 32'd1);
        if (model_ok) begin
            check({tag, "_done_wa"}, 32'(done_wa), 32'(exp_wa[n-1]));
            check({tag, "_done_we"}, 32'(done_we), 32'd1);
        end
        for (int i = 0; i < n; i++) ref_mem[exp_wa[i]] = exp_wd[i];
        for (int i = 0; i < cpu_exp_wa.size(); i++) ref_mem[cpu_exp_wa[i]] = cpu_exp_wd[i];
    endtask

    initial begin
        int bound, bad;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        bus.CPU_WA = 11'd5; bus.CPU_WD = 8'h77; bus.CPU_WE = 1'b1;
        bus.CMD_X0 = 6'd1; bus.CMD_Y0 = 5'd1; bus.CMD_W = 6'd2; bus.CMD_H = 5'd2;
        bus.CMD_COLOR = 8'hFF; bus.CMD_START = 1'b1;
        clear_log();

        // Reset held two cycles while inputs are active.
        RST = 1'b1;
        tick();
        tick();
        check("rst_fb_we", 32'(bus.FB_WE), 32'd0);
        check("rst_fb_wa", 32'(bus.FB_WA), 32'd0);
        check("rst_fb_wd", 32'(bus.FB_WD), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_err", 32'(bus.CMD_ERR), 32'd0);
        RST = 1'b0;
        idle_inputs();
        tick();

        do_cmd("basic", 2, 3, 4, 2, 8'hE0, -1, 0, 0, -1, 1'b0);
        do_cmd("clip", 38, 28, 5, 4, 8'h1C, -1, 0, 0, -1, 1'b0);
        do_cmd("arb", 2, 3, 4, 2, 8'hE0, 2, 3, 0, -1, 1'b0);
        do_cmd("rej_x", 40, 3, 4, 2, 8'h11, -1, 0, 0, -1, 1'b0);
        do_cmd("rej_w", 2, 3, 0, 2, 8'h11, -1, 0, 0, -1, 1'b0);
        do_cmd("rej_y", 2, 30, 3, 2, 8'h11, -1, 0, 0, -1, 1'b0);
        do_cmd("mid", 2, 3, 4, 2, 8'h9A, -1, 0, 0, 3, 1'b0);
        do_cmd("same", 10, 5, 3, 3, 8'h42, -1, 0, 0, -1, 1'b1);
        do_cmd("full", 0, 0, 40, 30, 8'hC3, -1, 0, 10, -1, 1'b0);

        for (int k = 0; k < 24; k++)
            do_cmd($sformatf("rnd%0d", k), int'($urandom_range(44)), int'($urandom_range(32)),
                   int'($urandom_range(12)), int'($urandom_range(6)), 8'($urandom),
                   -1, 0, 30, (k % 5 == 0) ? 2 : -1, k[0]);

        // Abort after the third fill write.
        clear_log();
        model_fill(2, 3, 4, 2, 8'h6D);
        bus.CMD_X0 = 6'd2; bus.CMD_Y0 = 5'd3; bus.CMD_W = 6'd4; bus.CMD_H = 5'd2;
        bus.CMD_COLOR = 8'h6D; bus.CMD_START = 1'b1;
        tick();
        idle_inputs();
        bound = 0;
        while (fill_wa_q.size() < 3 && bound < 50) begin
            tick();
            bound++;
        end
        check("abort_reached3", 32'(fill_wa_q.size()), 32'd3);
        RST = 1'b1;
        tick();
        check("abort_fb_we", 32'(bus.FB_WE), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_done", 32'(bus.DONE), 32'd0);
        tick();
        RST = 1'b0;
        tick(); tick(); tick();
        check("abort_nwrites", 32'(fill_wa_q.size()), 32'd3);
        check("abort_ndone", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 3; i++) ref_mem[exp_wa[i]] = exp_wd[i];

        // MCU write then read back at address 10 with the controller idle.
        cpu_exp_wa.delete(); cpu_exp_wd.delete();
        bus.CPU_WA = 11'd10; bus.CPU_WD = 8'hA5; bus.CPU_WE = 1'b1;
        tick();
        bus.CPU_WE = 1'b0;
        ref_mem[10] = 8'hA5;
        tick();
        tick();
        check("read_busy", 32'(bus.BUSY), 32'd0);
        check("read_fb_wa", 32'(bus.FB_WA), 32'd10);
        check("read_cpu_rd", 32'(bus.CPU_RD), 32'(ref_mem[10]));

        tick(); tick();
        bad = 0;
        for (int i = 0; i < 2048; i++) if (fb_mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_fb_fill_ctrl.md
Name: vga_fb_fill_ctrl

Overview:
- Controller that owns the write port of the 40x30 character-cell VGA framebuffer (2k x 8, address = {row[4:0], col[5:0]}).
- Shares the port between direct MCU writes and a hardware rectangle-fill engine that paints a clipped rectangle in one colour.
- Sits between the MCU I/O decode and the framebuffer driver's WA/WD/WE/RD inputs, on the 50 MHz system clock.

Parameters:
- COLS, 40, visible columns; x range 0..COLS-1.
- ROWS, 30, visible rows; y range 0..ROWS-1.

Ports:
- CLK  in  1  system clock (50 MHz); all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CPU_WA  in  11  MCU framebuffer address.
- CPU_WD  in  8  MCU write data (RGB 3:3:2).
- CPU_WE  in  1  MCU write enable.
- CPU_RD  out  8  MCU read data; equals FB_RD; valid only while BUSY=0.
- CMD_X0  in  6  rectangle left column.
- CMD_Y0  in  5  rectangle top row.
- CMD_W  in  6  rectangle width in cells.
- CMD_H  in  5  rectangle height in cells.
- CMD_COLOR  in  8  fill colour.
- CMD_START  in  1  start pulse; sampled only in IDLE.
- BUSY  out  1  high while in FILL.
- DONE  out  1  one-cycle pulse when the last fill write is presented.
- CMD_ERR  out  1  one-cycle pulse when a command is rejected.
- FB_WA  out  11  framebuffer address, registered.
- FB_WD  out  8  framebuffer write data, registered.
- FB_WE  out  1  framebuffer write enable, registered.
- FB_RD  in  8  framebuffer read data for the FB_WA address.

Behaviour:
- Reset: state IDLE; FB_WA=0, FB_WD=0, FB_WE=0, BUSY=0, DONE=0, CMD_ERR=0; latched command cleared.
- RST in FILL aborts the fill: the next cycle has FB_WE=0, and no DONE is issued.
- FB port registered, 1-cycle latency. At each edge:
  - if CPU_WE=1: FB_* <= CPU_WA/CPU_WD/1.
  - else if FILL: FB_* <= fill address/CMD_COLOR/1.
  - else: FB_WA <= CPU_WA, FB_WE <= 0, so MCU reads see their address.
- MCU always has priority. A fill stalls without advancing on any cycle with CPU_WE=1. No MCU write is ever dropped.
- FSM states: IDLE, FILL.
- IDLE with CMD_START=1, command invalid (CMD_X0>=COLS, CMD_Y0>=ROWS, CMD_W=0 or CMD_H=0):
  - CMD_ERR=1 next cycle; stay IDLE; no writes.
- IDLE with CMD_START=1, command valid:
  - latch x0, y0 and colour.
  - x_end = min(CMD_X0+CMD_W, COLS), computed 7-bit.
  - y_end = min(CMD_Y0+CMD_H, ROWS), computed 6-bit.
  - set x=x0, y=y0; go to FILL; BUSY=1 next cycle.
- FILL, each non-stalled cycle:
  - issue write at {y,x}.
  - if x=x_end-1: x <= x0, y <= y+1; else x <= x+1.
  - the issue at (x_end-1, y_end-1) is the last: go IDLE, DONE=1 the following cycle, together with the final FB_WE, and BUSY=0 that cycle.
- Write ordering: exactly one write per cell, row-major, top-left first.
- A full-screen fill takes 1200 issue cycles plus stalls.
- CMD_START while BUSY=1 is ignored (no latch, no CMD_ERR).
- CMD_START and CPU_WE in the same IDLE cycle: the MCU write goes through and the command is latched normally.
- Command inputs need only be stable in the CMD_START cycle.

Test Plan:
- Reset: assert RST 2 cycles mid-activity -> all outputs 0 the next cycle; FB_WE=0.
- Basic fill: X0=2, Y0=3, W=4, H=2, COLOR=0xE0 -> FB_WE pulses at addresses 194,195,196,197,258,259,260,261 in order, all data 0xE0; BUSY high 8 cycles; DONE with the write to 261.
- Clipping: X0=38, Y0=28, W=5, H=4, COLOR=0x1C -> exactly 4 writes: 1830, 1831, 1894, 1895; DONE once.
- Arbitration: during the basic fill, hold CPU_WE=1 for 3 cycles with WA=0x7FF, WD=0x55 -> three 0x55 writes to 0x7FF appear; all 8 fill writes still occur once each in order; BUSY lasts 11 cycles.
- Reject and ignore:
  - X0=40 -> CMD_ERR pulse, no FB_WE, BUSY stays 0.
  - W=0 -> CMD_ERR pulse.
  - second CMD_START mid-fill -> no effect on address sequence; no CMD_ERR.
- Abort: RST after the 3rd write of the basic fill -> FB_WE=0 next cycle, no DONE; a subsequent MCU read at address 10 returns FB_RD with BUSY=0.
